// File: rtl/boundary_scroll_ctrl_if.sv
// ---------------------------------------------------------------------------
// boundary_scroll_ctrl_if
// Frame-control and boundary-memory write signals of the scroll sequencer.
//   frame_start   : 1-cycle pulse at start of vertical blank (master -> slave)
//   enable        : 1 = scroll on frame_start, 0 = pause   (master -> slave)
//   speed[2:0]    : scroll steps per frame                 (master -> slave)
//   shift         : toggle line, one toggle = one row write (slave -> master)
//   row_data[39:0]: {lb, rb, il, ir}, 10 bits each          (slave -> master)
//   init_done     : initial fill has completed              (slave -> master)
//   busy          : sequencer not idle                      (slave -> master)
//   frame_overrun : sticky, a frame arrived while one was already queued
//   rows_total    : rows written since reset, wrapping      (slave -> master)
// ---------------------------------------------------------------------------
interface boundary_scroll_ctrl_if;
    logic        frame_start;
    logic        enable;
    logic [2:0]  speed;
    logic        shift;
    logic [39:0] row_data;
    logic        init_done;
    logic        busy;
    logic        frame_overrun;
    logic [15:0] rows_total;

    modport master (
        output frame_start, enable, speed,
        input  shift, row_data, init_done, busy, frame_overrun, rows_total
    );

    modport slave (
        input  frame_start, enable, speed,
        output shift, row_data, init_done, busy, frame_overrun, rows_total
    );
endinterface

// File: rtl/boundary_scroll_ctrl.sv
// ---------------------------------------------------------------------------
// boundary_scroll_ctrl
// Sequencer for the circular boundary memory holding the river edges.
// After reset it writes DEPTH rows; afterwards each accepted frame writes
// 'speed' rows. Every row is produced by an LFSR random walk of the river
// centre and half-width, driven on row_data, then committed by one toggle
// of shift, and held stable for SETTLE cycles.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high
//   bus   : boundary_scroll_ctrl_if.slave (frame control in, memory write out)
// ---------------------------------------------------------------------------
module boundary_scroll_ctrl #(
    parameter int          DEPTH     = 480,
    parameter int          SCREEN_W  = 640,
    parameter int          MIN_GAP   = 64,
    parameter int          MAX_STEP  = 4,
    parameter int          SETTLE    = 3,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  reset,
    boundary_scroll_ctrl_if.slave bus
);
    localparam int          AW      = 11;
    localparam int          REM_W   = $clog2(DEPTH + 1);
    localparam int          CNT_W   = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [39:0] ROW_RST = {10'd288, 10'd352, 10'd0, 10'd0};

    typedef logic signed [AW-1:0] sw_t;
    typedef enum logic [1:0] {ST_IDLE, ST_GEN, ST_TOGGLE, ST_SETTLE} state_t;

    // Code 0..7 becomes code-MAX_STEP; anything beyond +/-MAX_STEP is no move.
    function automatic sw_t step_from_code(input logic [2:0] code);
        sw_t d;
        d = $signed({8'd0, code}) - sw_t'(MAX_STEP);
        if (d > sw_t'(MAX_STEP) || d < -sw_t'(MAX_STEP)) begin
            d = '0;
        end
        return d;
    endfunction

    function automatic sw_t clamp(input sw_t v, input sw_t lo, input sw_t hi);
        sw_t r;
        r = v;
        if (v < lo) begin
            r = lo;
        end else if (v > hi) begin
            r = hi;
        end
        return r;
    endfunction

    state_t             state_q, state_d;
    logic               shift_q, shift_d;
    logic [39:0]        row_q, row_d;
    logic               init_done_q, init_done_d;
    logic               overrun_q, overrun_d;
    logic [15:0]        rows_q, rows_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic               pending_q, pending_d;
    logic [REM_W-1:0]   remaining_q, remaining_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // Row generator: works on the row currently driven and the advanced LFSR.
    logic [15:0] lfsr_adv;
    logic [10:0] edge_sum, edge_diff;
    sw_t         c0, h0, c1, h1, lb_n, rb_n, il_n, ir_n;
    logic        island;
    logic [39:0] row_new;

    always_comb begin
        lfsr_adv  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        edge_sum  = {1'b0, row_q[39:30]} + {1'b0, row_q[29:20]};
        // rb >= lb is an invariant of every row ever driven, so this never wraps.
        edge_diff = {1'b0, row_q[29:20]} - {1'b0, row_q[39:30]};
        c0        = $signed({1'b0, edge_sum[10:1]});
        h0        = $signed({1'b0, edge_diff[10:1]});
        h1        = clamp(h0 + step_from_code(lfsr_adv[5:3]),
                          sw_t'(MIN_GAP / 2), sw_t'(SCREEN_W / 4));
        c1        = clamp(c0 + step_from_code(lfsr_adv[2:0]),
                          h1, sw_t'(SCREEN_W - 1) - h1);
        lb_n      = c1 - h1;
        rb_n      = c1 + h1;
        island    = (lfsr_adv[15:12] == 4'hF) && (h1 >= sw_t'(48));
        il_n      = island ? c1 - sw_t'(8) : '0;
        ir_n      = island ? c1 + sw_t'(8) : '0;
        row_new   = {lb_n[9:0], rb_n[9:0], il_n[9:0], ir_n[9:0]};
    end

    // After clamping every field is in 0..SCREEN_W-1; the dropped bits are zero.
    logic unused_bits;
    assign unused_bits = ^{edge_sum[0], edge_diff[0], lb_n[10], rb_n[10], il_n[10], ir_n[10]};

    logic accept, consume;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        row_d       = row_q;
        init_done_d = init_done_q;
        overrun_d   = overrun_q;
        rows_d      = rows_q;
        lfsr_d      = lfsr_q;
        pending_d   = pending_q;
        remaining_d = remaining_q;
        cnt_d       = cnt_q;

        accept  = bus.frame_start && bus.enable && init_done_q;
        // A queued frame is always retired in IDLE, even with speed==0.
        consume = (state_q == ST_IDLE) && init_done_q && pending_q;

        unique case (state_q)
            ST_IDLE: begin
                if (!init_done_q) begin
                    state_d     = ST_GEN;
                    remaining_d = REM_W'(DEPTH);
                end else if (pending_q && bus.speed != 3'd0) begin
                    state_d     = ST_GEN;
                    remaining_d = REM_W'(bus.speed);
                end
            end
            ST_GEN: begin
                lfsr_d  = lfsr_adv;
                row_d   = row_new;
                state_d = ST_TOGGLE;
            end
            ST_TOGGLE: begin
                shift_d     = ~shift_q;
                rows_d      = rows_q + 16'd1;
                remaining_d = remaining_q - REM_W'(1);
                cnt_d       = '0;
                state_d     = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE - 1)) begin
                    if (remaining_q != '0) begin
                        state_d = ST_GEN;
                    end else begin
                        init_done_d = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase

        // A frame arriving in the same cycle the queued one is retired takes its slot.
        if (accept) begin
            if (pending_q && !consume) begin
                overrun_d = 1'b1;
            end else begin
                pending_d = 1'b1;
            end
        end else if (consume) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            shift_q     <= 1'b0;
            row_q       <= ROW_RST;
            init_done_q <= 1'b0;
            overrun_q   <= 1'b0;
            rows_q      <= '0;
            lfsr_q      <= LFSR_SEED;
            pending_q   <= 1'b0;
            remaining_q <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            row_q       <= row_d;
            init_done_q <= init_done_d;
            overrun_q   <= overrun_d;
            rows_q      <= rows_d;
            lfsr_q      <= lfsr_d;
            pending_q   <= pending_d;
            remaining_q <= remaining_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.shift         = shift_q;
    assign bus.row_data      = row_q;
    assign bus.init_done     = init_done_q;
    assign bus.busy          = (state_q != ST_IDLE);
    assign bus.frame_overrun = overrun_q;
    assign bus.rows_total    = rows_q;
endmodule
